// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: 1-bit/cycle shift-add multiplier and restoring divider.
// Optional MULDIV_EARLY_OUT_EN: multiply finishes as soon as the remaining multiplier bits are zero.
module muldiv_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            START,
  output logic            READY,
  input  logic [4:0]      SELECT,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  input  logic            FLUSH,
  output logic [XLEN-1:0] RESULT,
  output logic            RESULT_VALID,
  input  logic            RESULT_READY,
  output logic            BUSY
);

  localparam logic [4:0] OP_MUL    = 5'b01001;
  localparam logic [4:0] OP_MULH   = 5'b01010;
  localparam logic [4:0] OP_MULHU  = 5'b01011;
  localparam logic [4:0] OP_MULHSU = 5'b01100;
  localparam logic [4:0] OP_DIV    = 5'b01101;
  localparam logic [4:0] OP_DIVU   = 5'b01110;
  localparam logic [4:0] OP_REM    = 5'b01111;
  localparam logic [4:0] OP_REMU   = 5'b10000;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_MUL_RUN, S_DIV_RUN, S_FIXUP, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [4:0]          op_q;
  logic [2*XLEN-1:0]   acc_q;
  logic [XLEN-1:0]     opb_q;
  logic [XLEN-1:0]     mplier_q;
  logic                neg_res_q;
  logic                neg_rem_q;

  function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] x);
    return (~x) + XLEN'(1);
  endfunction

  function automatic logic [2*XLEN-1:0] neg_d(input logic [2*XLEN-1:0] x);
    return (~x) + (2*XLEN)'(1);
  endfunction

  logic            is_mul_in, is_div_in, is_rem_in, a_signed_in, b_signed_in;
  logic            a_neg_in, b_neg_in, div_zero_in, ovf_in, fast_in, accept;
  logic [XLEN-1:0] a_mag_in, b_mag_in, fast_res_in;

  always_comb begin
    is_mul_in   = 1'b0;
    is_div_in   = 1'b0;
    is_rem_in   = 1'b0;
    a_signed_in = 1'b0;
    b_signed_in = 1'b0;
    case (SELECT)
      OP_MUL, OP_MULHU: is_mul_in = 1'b1;
      OP_MULH: begin
        is_mul_in   = 1'b1;
        a_signed_in = 1'b1;
        b_signed_in = 1'b1;
      end
      OP_MULHSU: begin
        is_mul_in   = 1'b1;
        a_signed_in = 1'b1;
      end
      OP_DIV: begin
        is_div_in   = 1'b1;
        a_signed_in = 1'b1;
        b_signed_in = 1'b1;
      end
      OP_REM: begin
        is_div_in   = 1'b1;
        is_rem_in   = 1'b1;
        a_signed_in = 1'b1;
        b_signed_in = 1'b1;
      end
      OP_DIVU: is_div_in = 1'b1;
      OP_REMU: begin
        is_div_in = 1'b1;
        is_rem_in = 1'b1;
      end
      default: ;
    endcase

    a_neg_in    = a_signed_in & DATA1[XLEN-1];
    b_neg_in    = b_signed_in & DATA2[XLEN-1];
    a_mag_in    = a_neg_in ? neg_w(DATA1) : DATA1;
    b_mag_in    = b_neg_in ? neg_w(DATA2) : DATA2;
    div_zero_in = is_div_in && (DATA2 == '0);
    ovf_in      = is_div_in && a_signed_in && (DATA1 == MIN_NEG) && (DATA2 == '1);
    fast_in     = !(is_mul_in || is_div_in) || div_zero_in || ovf_in;

    fast_res_in = '0;
    if (div_zero_in)
      fast_res_in = is_rem_in ? DATA1 : '1;
    else if (ovf_in)
      fast_res_in = is_rem_in ? '0 : MIN_NEG;

    accept = START && READY && !FLUSH;
  end

  // Iteration step: multiply adds into the upper half then shifts right;
  // divide shifts {remainder, quotient} left and trial-subtracts.
  logic [XLEN-1:0]   mul_addend;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_step, mul_next;
  logic [XLEN:0]     div_trial;
  logic [2*XLEN-1:0] div_step;
  logic              cnt_last, mul_done;

  always_comb begin
    cnt_last   = (cnt_q == CNT_W'(XLEN-1));
    mul_addend = mplier_q[0] ? opb_q : '0;
    mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mul_addend};
    mul_step   = {mul_sum, acc_q[XLEN-1:1]};
`ifdef MULDIV_EARLY_OUT_EN
    mul_done   = cnt_last || (mplier_q[XLEN-1:1] == '0);
    mul_next   = mul_step >> (CNT_W'(XLEN-1) - cnt_q);
`else
    mul_done   = cnt_last;
    mul_next   = mul_step;
`endif
    div_trial  = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opb_q};
    div_step   = div_trial[XLEN]
               ? {acc_q[2*XLEN-2:0], 1'b0}
               : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  end

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

  always_comb begin
    prod_fix = neg_res_q ? neg_d(acc_q) : acc_q;
    quo_fix  = neg_res_q ? neg_w(acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
    rem_fix  = neg_rem_q ? neg_w(acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                     fix_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHU, OP_MULHSU: fix_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:            fix_res = quo_fix;
      OP_REM, OP_REMU:            fix_res = rem_fix;
      default:                    fix_res = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (FLUSH) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:
          if (START) state_d = fast_in ? S_DONE : (is_mul_in ? S_MUL_RUN : S_DIV_RUN);
        S_MUL_RUN: if (mul_done) state_d = S_FIXUP;
        S_DIV_RUN: if (cnt_last) state_d = S_FIXUP;
        S_FIXUP:   state_d = S_DONE;
        S_DONE:    if (RESULT_READY) state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    READY        = (state_q == S_IDLE);
    BUSY         = (state_q != S_IDLE);
    RESULT_VALID = (state_q == S_DONE);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q     <= '0;
      op_q      <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      mplier_q  <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      RESULT    <= '0;
    end else begin
      case (state_q)
        S_IDLE:
          if (accept) begin
            op_q      <= SELECT;
            cnt_q     <= '0;
            neg_res_q <= a_neg_in ^ b_neg_in;
            neg_rem_q <= a_neg_in;
            if (fast_in) begin
              RESULT <= fast_res_in;
            end else if (is_mul_in) begin
              acc_q    <= '0;
              opb_q    <= a_mag_in;
              mplier_q <= b_mag_in;
            end else begin
              acc_q <= {{XLEN{1'b0}}, a_mag_in};
              opb_q <= b_mag_in;
            end
          end
        S_MUL_RUN: begin
          acc_q    <= mul_next;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
        end
        S_DIV_RUN: begin
          acc_q <= div_step;
          cnt_q <= cnt_q + CNT_W'(1);
        end
        S_FIXUP: RESULT <= fix_res;
        default: ;
      endcase
    end
  end

endmodule
